// File: rtl/fft_pkg.sv
// Shared types and helpers for the FFT stage sequencer.
// FSM encodings, beat bundle and bit-reversal helper.
package fft_pkg;

    localparam int unsigned FFT_LOG2N = 6;
    localparam int unsigned FFT_N     = 1 << FFT_LOG2N;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_BITREV = 3'd1;
    localparam logic [2:0] ST_STAGE  = 3'd2;
    localparam logic [2:0] ST_DRAIN  = 3'd3;
    localparam logic [2:0] ST_DONE   = 3'd4;

    typedef struct packed {
        logic                   swap;
        logic [FFT_LOG2N-1:0]   addr_a;
        logic [FFT_LOG2N-1:0]   addr_b;
        logic [FFT_LOG2N-2:0]   tw_idx;
        logic [2:0]             stage;
    } beat_t;

    function automatic logic [FFT_LOG2N-1:0] bitrev(
        input logic [FFT_LOG2N-1:0] v
    );
        logic [FFT_LOG2N-1:0] r;
        for (int j = 0; j < FFT_LOG2N; j++) begin
            r[j] = v[FFT_LOG2N-1-j];
        end
        return r;
    endfunction

endpackage

// File: rtl/fft_stage_sequencer_addr_gen.sv
// Combinational butterfly address generator: (k, s) -> operand
// addresses and twiddle index for an in-place radix-2 DIT FFT.
module fft_addr_gen #(
    parameter int unsigned LOG2N = 6
) (
    input  logic [LOG2N-2:0] k_i,
    input  logic [2:0]       s_i,
    output logic [LOG2N-1:0] addr_a_o,
    output logic [LOG2N-1:0] addr_b_o,
    output logic [LOG2N-2:0] tw_idx_o
);

    logic [LOG2N-1:0] half;
    logic [LOG2N-2:0] mask;
    logic [LOG2N-2:0] pos;
    logic [LOG2N-2:0] grp;

    always_comb begin
        half     = {{(LOG2N-1){1'b0}}, 1'b1} << s_i;
        mask     = ~({(LOG2N-1){1'b1}} << s_i);
        pos      = k_i & mask;
        grp      = k_i >> s_i;
        addr_a_o = ({1'b0, grp} << (s_i + 3'd1)) | {1'b0, pos};
        // bit s of addr_a is always clear, so the add never carries
        addr_b_o = addr_a_o + half;
        tw_idx_o = pos << (3'(LOG2N - 1) - s_i);
    end

endmodule

// File: rtl/fft_stage_sequencer.sv
// Radix-2 DIT FFT command sequencer with inter-stage drain gaps.
// Define FFT_SEQ_BITREV_EN to add the bit-reverse swap pass.
module fft_stage_sequencer
    import fft_pkg::*;
#(
    parameter int unsigned PIPE_LAT = 3
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 abort,
    output logic                 busy,
    output logic                 done,
    output logic                 cmd_valid,
    input  logic                 cmd_ready,
    output logic                 cmd_swap,
    output logic [FFT_LOG2N-1:0] addr_a,
    output logic [FFT_LOG2N-1:0] addr_b,
    output logic [FFT_LOG2N-2:0] tw_idx,
    output logic [2:0]           stage
);

    localparam int unsigned LOG2N = FFT_LOG2N;
    localparam int unsigned CW    = (PIPE_LAT > 1) ? $clog2(PIPE_LAT) : 1;
    localparam logic [LOG2N-2:0] KMAX = '1;
    localparam logic [CW-1:0]    CLAST = CW'(PIPE_LAT - 1);
    localparam logic [2:0]       SLAST = 3'(LOG2N - 1);

    logic [2:0]       state_q, state_d;
    logic [LOG2N-2:0] k_q, k_d;
    logic [2:0]       s_q, s_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             valid_q, valid_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    beat_t            beat_q, beat_d;
    logic             rev_pass;

`ifdef FFT_SEQ_BITREV_EN
    logic [LOG2N:0]   i_q, i_d;
    logic             rev_q, rev_d;
    logic [LOG2N-1:0] rv;

    assign rev_pass = rev_q;
    assign rv       = bitrev(i_q[LOG2N-1:0]);
`else
    assign rev_pass = 1'b0;
`endif

    logic [LOG2N-2:0] k_sel;
    logic [2:0]       s_sel;
    logic [LOG2N-1:0] ga;
    logic [LOG2N-1:0] gb;
    logic [LOG2N-2:0] gt;

    fft_addr_gen #(
        .LOG2N(LOG2N)
    ) u_gen (
        .k_i     (k_sel),
        .s_i     (s_sel),
        .addr_a_o(ga),
        .addr_b_o(gb),
        .tw_idx_o(gt)
    );

    always_comb begin
        k_sel = k_q;
        s_sel = s_q;
        if (state_q == ST_DRAIN) begin
            k_sel = '0;
            s_sel = rev_pass ? 3'd0 : s_q + 3'd1;
        end else if (state_q == ST_STAGE && valid_q) begin
            k_sel = k_q + 1'b1;
        end
    end

    always_comb begin
        state_d = state_q;
        k_d     = k_q;
        s_d     = s_q;
        cnt_d   = cnt_q;
        valid_d = valid_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        beat_d  = beat_q;
`ifdef FFT_SEQ_BITREV_EN
        i_d     = i_q;
        rev_d   = rev_q;
`endif
        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    busy_d = 1'b1;
                    k_d    = '0;
                    s_d    = '0;
`ifdef FFT_SEQ_BITREV_EN
                    state_d = ST_BITREV;
                    i_d     = '0;
                    rev_d   = 1'b1;
`else
                    state_d = ST_STAGE;
`endif
                end
            end
`ifdef FFT_SEQ_BITREV_EN
            ST_BITREV: begin
                if (!valid_q || cmd_ready) begin
                    if (i_q[LOG2N]) begin
                        valid_d = 1'b0;
                        cnt_d   = '0;
                        state_d = ST_DRAIN;
                    end else begin
                        i_d     = i_q + 1'b1;
                        valid_d = (rv > i_q[LOG2N-1:0]);
                        beat_d  = '{swap: 1'b1, addr_a: i_q[LOG2N-1:0],
                                    addr_b: rv, tw_idx: '0, stage: '0};
                    end
                end
            end
`endif
            ST_STAGE: begin
                if (!valid_q || (cmd_ready && k_q != KMAX)) begin
                    valid_d = 1'b1;
                    k_d     = k_sel;
                    beat_d  = '{swap: 1'b0, addr_a: ga, addr_b: gb,
                                tw_idx: gt, stage: s_sel};
                end else if (cmd_ready) begin
                    valid_d = 1'b0;
                    cnt_d   = '0;
                    state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (cnt_q != CLAST) begin
                    cnt_d = cnt_q + 1'b1;
                end else if (!rev_pass && s_q == SLAST) begin
                    state_d = ST_DONE;
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                end else begin
                    // first beat of the next stage issues on the gap's last edge
                    state_d = ST_STAGE;
                    s_d     = s_sel;
                    k_d     = '0;
                    valid_d = 1'b1;
                    beat_d  = '{swap: 1'b0, addr_a: ga, addr_b: gb,
                                tw_idx: gt, stage: s_sel};
`ifdef FFT_SEQ_BITREV_EN
                    rev_d   = 1'b0;
`endif
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
                valid_d = 1'b0;
                busy_d  = 1'b0;
            end
        endcase
        if (abort) begin
            state_d = ST_IDLE;
            valid_d = 1'b0;
            busy_d  = 1'b0;
            done_d  = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            k_q     <= '0;
            s_q     <= '0;
            cnt_q   <= '0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            beat_q  <= '0;
`ifdef FFT_SEQ_BITREV_EN
            i_q     <= '0;
            rev_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
            s_q     <= s_d;
            cnt_q   <= cnt_d;
            valid_q <= valid_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            beat_q  <= beat_d;
`ifdef FFT_SEQ_BITREV_EN
            i_q     <= i_d;
            rev_q   <= rev_d;
`endif
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign cmd_valid = valid_q;
    assign cmd_swap  = beat_q.swap;
    assign addr_a    = beat_q.addr_a;
    assign addr_b    = beat_q.addr_b;
    assign tw_idx    = beat_q.tw_idx;
    assign stage     = beat_q.stage;

endmodule

// File: tb/tb_fft_stage_sequencer.sv
// Scoreboard bench for fft_stage_sequencer (N=64, PIPE_LAT=3).
// Define FFT_SEQ_BITREV_EN to also cover the swap pass.
module tb_fft_stage_sequencer;
    import fft_pkg::*;

    localparam int L   = FFT_LOG2N;
    localparam int N   = FFT_N;
    localparam int LAT = 3;

    typedef struct packed {
        logic         swap;
        logic [L-1:0] a;
        logic [L-1:0] b;
        logic [L-2:0] tw;
        logic [2:0]   st;
    } vec_t;

    typedef struct packed {
        vec_t v;
        int   k;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst, start, abort, cmd_ready;
    logic         busy, done, cmd_valid, cmd_swap;
    logic [L-1:0] addr_a, addr_b;
    logic [L-2:0] tw_idx;
    logic [2:0]   stage;
    vec_t         obs;

    int   n_cmp = 0;
    int   n_bad = 0;
    exp_t exp_q[$];

    fft_stage_sequencer #(.PIPE_LAT(LAT)) dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort),
        .busy(busy), .done(done), .cmd_valid(cmd_valid),
        .cmd_ready(cmd_ready), .cmd_swap(cmd_swap),
        .addr_a(addr_a), .addr_b(addr_b), .tw_idx(tw_idx), .stage(stage)
    );

    always #5 clk = ~clk;
    assign obs = {cmd_swap, addr_a, addr_b, tw_idx, stage};

    function automatic int rev_model(input int i);
        int r = 0;
        int x = i;
        repeat (L) begin
            r = r * 2 + x % 2;
            x = x / 2;
        end
        return r;
    endfunction

    task automatic load_model();
        exp_t e;
        exp_q.delete();
`ifdef FFT_SEQ_BITREV_EN
        for (int i = 0; i < N; i++) begin
            if (rev_model(i) > i) begin
                e.v = {1'b1, L'(i), L'(rev_model(i)), (L-1)'(0), 3'd0};
                e.k = 0;
                exp_q.push_back(e);
            end
        end
`endif
        for (int s = 0; s < L; s++) begin
            int h = 1 << s;
            for (int g = 0; g < N / (2 * h); g++) begin
                for (int p = 0; p < h; p++) begin
                    e.v.swap = 1'b0;
                    e.v.a    = L'(g * 2 * h + p);
                    e.v.b    = L'(g * 2 * h + p + h);
                    e.v.tw   = (L-1)'(p * (N / (2 * h)));
                    e.v.st   = 3'(s);
                    e.k      = g * h + p;
                    exp_q.push_back(e);
                end
            end
        end
    endtask

    task automatic pulse_start();
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; abort = 1'b0; cmd_ready = 1'b1;
        #12;
        n_cmp++;
        if ({busy, done, cmd_valid, obs} !== '0) begin
            n_bad++;
            $display("FAIL reset_outputs: got %h want 0",
                     {busy, done, cmd_valid, obs});
        end
        @(posedge clk); #1 rst = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_cmp++;
        if ({busy, done, cmd_valid} !== 3'b000) begin
            n_bad++;
            $display("FAIL reset_idle: got %b want 000", {busy, done, cmd_valid});
        end
    endtask

    task automatic test_full_rate();
        exp_t e;
        int cyc = 0, c0 = -1, beats = 0, swaps = 0, gap = 0, dups = 0;
        int cur_s = -1, dcyc = -1;
        bit last_k = 0;
        logic [N-1:0] seen = '0;
        load_model();
        cmd_ready = 1'b1;
        pulse_start();
        while (dcyc < 0 && cyc < 2000) begin
            @(negedge clk);
            cyc++;
            if (done) dcyc = cyc;
            if (cmd_valid) begin
                if (last_k) begin
                    n_cmp++;
                    if (gap !== LAT) begin
                        n_bad++;
                        $display("FAIL drain_gap: got %0d want %0d", gap, LAT);
                    end
                    last_k = 0;
                end
                gap = 0;
                if (exp_q.size() == 0) begin
                    n_cmp++; n_bad++;
                    $display("FAIL extra_beat: got %h want none", obs);
                end else begin
                    e = exp_q.pop_front();
                    n_cmp++;
                    if (obs !== e.v) begin
                        n_bad++;
                        $display("FAIL beat: got %h want %h", obs, e.v);
                    end
                    if (e.v.swap) begin
                        if (swaps == 0 || swaps == 1) begin
                            n_cmp++;
                            if ({addr_a, addr_b} !== (swaps == 0 ?
                                {6'd1, 6'd32} : {6'd2, 6'd16})) begin
                                n_bad++;
                                $display("FAIL swap%0d: got a=%0d b=%0d",
                                         swaps, addr_a, addr_b);
                            end
                        end
                        swaps++;
                    end else begin
                        if (c0 < 0) c0 = cyc;
                        beats++;
                        if (e.v.st != cur_s) begin
                            cur_s = e.v.st;
                            seen = '0;
                        end
                        if (seen[addr_a] || seen[addr_b]) dups++;
                        seen[addr_a] = 1'b1;
                        seen[addr_b] = 1'b1;
                        if (e.k == N / 2 - 1) last_k = 1;
                        if ((e.v.st == 0 && e.k < 2) ||
                            (e.v.st == 2 && e.k == 5) ||
                            (e.v.st == 5 && e.k == 31)) begin
                            n_cmp++;
                            if ({addr_a, addr_b, tw_idx} !==
                                (e.v.st == 2 ? {6'd9, 6'd13, 5'd8} :
                                 e.v.st == 5 ? {6'd31, 6'd63, 5'd31} :
                                 e.k == 0 ? {6'd0, 6'd1, 5'd0} :
                                 {6'd2, 6'd3, 5'd0})) begin
                                n_bad++;
                                $display("FAIL addr_s%0d_k%0d: got a=%0d b=%0d tw=%0d",
                                         e.v.st, e.k, addr_a, addr_b, tw_idx);
                            end
                        end
                    end
                end
            end else begin
                gap++;
            end
        end
        n_cmp++;
        if (dcyc < 0 || dcyc - c0 != N / 2 * L + L * LAT) begin
            n_bad++;
            $display("FAIL done_time: got %0d want %0d", dcyc - c0,
                     N / 2 * L + L * LAT);
        end
        n_cmp++;
        if (beats != N / 2 * L || exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL beat_count: got %0d left %0d want %0d",
                     beats, exp_q.size(), N / 2 * L);
        end
        n_cmp++;
        if (dups != 0) begin
            n_bad++;
            $display("FAIL dup_addr: got %0d want 0", dups);
        end
`ifdef FFT_SEQ_BITREV_EN
        n_cmp++;
        if (swaps != 28) begin
            n_bad++;
            $display("FAIL swap_count: got %0d want 28", swaps);
        end
`endif
        @(negedge clk);
        n_cmp++;
        if ({done, busy} !== 2'b00) begin
            n_bad++;
            $display("FAIL done_pulse: got done,busy=%b want 00", {done, busy});
        end
    endtask

    task automatic test_stall();
        exp_t e;
        int cyc = 0;
        bit stalled = 0;
        bit fin = 0;
        vec_t held;
        load_model();
        pulse_start();
        while (!fin && cyc < 4000) begin
            @(posedge clk); #1 cmd_ready = 1'($urandom_range(0, 1));
            @(negedge clk);
            cyc++;
            if (done) fin = 1;
            if (stalled) begin
                n_cmp++;
                if (!cmd_valid || obs !== held) begin
                    n_bad++;
                    $display("FAIL stall_hold: got v=%b %h want 1 %h",
                             cmd_valid, obs, held);
                end
            end
            stalled = 0;
            if (cmd_valid && cmd_ready) begin
                if (exp_q.size() == 0) begin
                    n_cmp++; n_bad++;
                    $display("FAIL stall_extra: got %h want none", obs);
                end else begin
                    e = exp_q.pop_front();
                    n_cmp++;
                    if (obs !== e.v) begin
                        n_bad++;
                        $display("FAIL stall_beat: got %h want %h", obs, e.v);
                    end
                end
            end else if (cmd_valid) begin
                stalled = 1;
                held = obs;
            end
        end
        cmd_ready = 1'b1;
        n_cmp++;
        if (!fin || exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL stall_done: got done=%b left=%0d want 1 0",
                     fin, exp_q.size());
        end
    endtask

    task automatic test_abort();
        exp_t e;
        int cyc = 0;
        bit hit = 0;
        bit bad = 0;
        load_model();
        cmd_ready = 1'b1;
        pulse_start();
        while (!hit && cyc < 2000) begin
            @(negedge clk);
            cyc++;
            if (cmd_valid && exp_q.size() != 0) begin
                e = exp_q.pop_front();
                n_cmp++;
                if (obs !== e.v) begin
                    n_bad++;
                    $display("FAIL abort_beat: got %h want %h", obs, e.v);
                end
                if (!e.v.swap && e.v.st == 3 && e.k == 10) hit = 1;
            end
        end
        n_cmp++;
        if (!hit) begin
            n_bad++;
            $display("FAIL abort_reach: got none want s3k10");
        end
        #1 abort = 1'b1;
        @(posedge clk); #1 abort = 1'b0;
        n_cmp++;
        if ({busy, cmd_valid} !== 2'b00) begin
            n_bad++;
            $display("FAIL abort_exit: got busy,valid=%b want 00",
                     {busy, cmd_valid});
        end
        repeat (300) begin
            @(negedge clk);
            if (done || busy || cmd_valid) bad = 1;
        end
        n_cmp++;
        if (bad) begin
            n_bad++;
            $display("FAIL abort_quiet: got activity want none");
        end
        load_model();
        while (exp_q.size() != 0 && exp_q[0].v.swap) void'(exp_q.pop_front());
        pulse_start();
        hit = 0;
        cyc = 0;
        while (!hit && cyc < 200) begin
            @(negedge clk);
            cyc++;
            if (cmd_valid && !cmd_swap) hit = 1;
        end
        e = exp_q.pop_front();
        n_cmp++;
        if (!hit || obs !== e.v) begin
            n_bad++;
            $display("FAIL restart_beat: got %h want %h", obs, e.v);
        end
        #1 abort = 1'b1;
        @(posedge clk); #1 abort = 1'b0;
        repeat (2) @(posedge clk);
    endtask

    task automatic test_busy_rst();
        exp_t e;
        int cyc = 0;
        bit hit = 0;
        bit bad = 0;
        load_model();
        cmd_ready = 1'b1;
        pulse_start();
        while (!hit && cyc < 2000) begin
            @(negedge clk);
            cyc++;
            start = 1'b0;
            if (cmd_valid && exp_q.size() != 0) begin
                e = exp_q.pop_front();
                n_cmp++;
                if (obs !== e.v || !busy) begin
                    n_bad++;
                    $display("FAIL busy_beat: got %h busy=%b want %h 1",
                             obs, busy, e.v);
                end
                if (!e.v.swap && e.v.st == 1 && e.k == 0) start = 1'b1;
                if (!e.v.swap && e.v.st == 4 && e.k == 7) hit = 1;
            end
        end
        #2 rst = 1'b1;
        #1;
        n_cmp++;
        if ({busy, done, cmd_valid, obs} !== '0) begin
            n_bad++;
            $display("FAIL async_rst: got %h want 0",
                     {busy, done, cmd_valid, obs});
        end
        @(posedge clk); #1 rst = 1'b0;
        repeat (20) begin
            @(negedge clk);
            if (busy || cmd_valid || done) bad = 1;
        end
        @(posedge clk); #1 start = 1'b1; abort = 1'b1;
        @(posedge clk); #1 start = 1'b0; abort = 1'b0;
        repeat (5) begin
            @(negedge clk);
            if (busy || cmd_valid || done) bad = 1;
        end
        n_cmp++;
        if (bad) begin
            n_bad++;
            $display("FAIL idle_after_rst: got activity want none");
        end
    endtask

    initial begin
        test_reset();
        test_full_rate();
        test_stall();
        test_abort();
        test_busy_rst();
        test_full_rate();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
